// File: rtl/basys_display_mux.sv
// Multiplexed seven-segment driver: captures a result word through valid/ready
// and scans DIGITS hex digits at a programmable rate, with leading-zero blanking.
module basys_display_mux #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [4*DIGITS-1:0] in_data,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                freeze,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] shown,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]     div_cnt_reg, div_cnt_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [DW-1:0]     shown_reg, shown_next;
    logic [DIGITS-1:0] dp_mask_reg, dp_mask_next;
    logic [DIGITS-1:0] an_reg, an_next;
    logic [6:0]        seg_reg, seg_next;
    logic              dp_pin_reg, dp_pin_next;

    logic              tick;
    logic              handshake;
    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] blank_vec;
    logic              zero_run;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic              cur_dp;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign in_ready  = ~freeze;
    assign handshake = in_valid & ~freeze;
    assign tick      = (div_cnt_reg == DIV_LAST);

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = shown_reg[4*gi +: 4];
    end

    // A digit is blankable when it and every more-significant nibble are zero.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (nib[i] == 4'h0);
            blank_vec[i] = (BLANK_LZ != 0) && (i != 0) && zero_run;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IW'(i)) begin
                cur_nib   = nib[i];
                cur_blank = blank_vec[i];
                cur_dp    = dp_mask_reg[i];
            end
        end
    end

    always_comb begin
        div_cnt_next = tick ? '0 : div_cnt_reg + CW'(1);
        idx_next     = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
        shown_next   = handshake ? in_data : shown_reg;
        dp_mask_next = handshake ? dp_in : dp_mask_reg;
    end

    // Pins follow the current slot one cycle later; new idx and new data land together.
    always_comb begin
        an_next     = '1;
        seg_next    = 7'h7F;
        dp_pin_next = 1'b1;
        if (!cur_blank) begin
            an_next     = ~(DIGITS'(1) << idx_reg);
            seg_next    = hex_to_seg(cur_nib);
            dp_pin_next = ~cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
            shown_reg   <= '0;
            dp_mask_reg <= '0;
            an_reg      <= '1;
            seg_reg     <= 7'h7F;
            dp_pin_reg  <= 1'b1;
        end else begin
            div_cnt_reg <= div_cnt_next;
            idx_reg     <= idx_next;
            shown_reg   <= shown_next;
            dp_mask_reg <= dp_mask_next;
            an_reg      <= an_next;
            seg_reg     <= seg_next;
            dp_pin_reg  <= dp_pin_next;
        end
    end

    assign shown = shown_reg;
    assign an    = an_reg;
    assign seg   = seg_reg;
    assign dp    = dp_pin_reg;

endmodule

// File: tb/tb_basys_display_mux.sv
// Bench for basys_display_mux: three configurations share one stimulus stream,
// a cycle model feeds a scoreboard queue and directed checks cover the key cases.
module tb_basys_display_mux;
    localparam int NK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, freeze;
    logic [15:0] in_data;
    logic [3:0]  dp_in;

    logic        in_ready_a, in_ready_b, in_ready_c;
    logic [15:0] shown_a, shown_b;
    logic [3:0]  shown_c;
    logic [3:0]  an_a, an_b;
    logic [0:0]  an_c;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic        dp_a, dp_b, dp_c;

    basys_display_mux #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .dp_in(dp_in),
        .freeze(freeze), .in_ready(in_ready_a), .shown(shown_a), .an(an_a), .seg(seg_a), .dp(dp_a)
    );
    basys_display_mux #(.DIGITS(4), .SCAN_DIV(4), .BLANK_LZ(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .dp_in(dp_in),
        .freeze(freeze), .in_ready(in_ready_b), .shown(shown_b), .an(an_b), .seg(seg_b), .dp(dp_b)
    );
    basys_display_mux #(.DIGITS(1), .SCAN_DIV(2), .BLANK_LZ(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[3:0]), .dp_in(dp_in[0:0]),
        .freeze(freeze), .in_ready(in_ready_c), .shown(shown_c), .an(an_c), .seg(seg_c), .dp(dp_c)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int digs_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction
    function automatic int div_of(input int k);
        return (k == 2) ? 2 : 4;
    endfunction
    function automatic int blz_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    typedef struct {
        logic [2:0][3:0]  an;
        logic [2:0][6:0]  seg;
        logic [2:0]       dp;
        logic [2:0][15:0] shown;
    } exp_t;
    exp_t sb[$];

    int          m_div [NK];
    int          m_idx [NK];
    logic [15:0] m_shown [NK];
    logic [3:0]  m_dp [NK];

    // Reference model: expected pins for the state before the edge, then advance.
    always @(posedge clk) begin
        exp_t e;
        for (int k = 0; k < NK; k++) begin
            int d, mask, an_i;
            d    = digs_of(k);
            mask = (1 << d) - 1;
            if (rst) begin
                e.an[k] = 4'(mask); e.seg[k] = 7'h7F; e.dp[k] = 1'b1;
                m_div[k] = 0; m_idx[k] = 0; m_shown[k] = '0; m_dp[k] = '0;
            end else begin
                if (blz_of(k) == 1 && m_idx[k] > 0 && (m_shown[k] >> (4 * m_idx[k])) == 16'h0) begin
                    e.an[k] = 4'(mask); e.seg[k] = 7'h7F; e.dp[k] = 1'b1;
                end else begin
                    an_i     = mask & ~(1 << m_idx[k]);
                    e.an[k]  = 4'(an_i);
                    e.seg[k] = seg_of(4'(m_shown[k] >> (4 * m_idx[k])));
                    e.dp[k]  = ~m_dp[k][m_idx[k]];
                end
                if (m_div[k] == div_of(k) - 1) begin
                    m_div[k] = 0;
                    m_idx[k] = (m_idx[k] == d - 1) ? 0 : m_idx[k] + 1;
                end else begin
                    m_div[k] = m_div[k] + 1;
                end
                if (in_valid && !freeze) begin
                    m_shown[k] = in_data & 16'((1 << (4 * d)) - 1);
                    m_dp[k]    = dp_in & 4'(mask);
                end
            end
            e.shown[k] = m_shown[k];
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("an_a", 32'(an_a), 32'(e.an[0]));
            check("seg_a", 32'(seg_a), 32'(e.seg[0]));
            check("dp_a", 32'(dp_a), 32'(e.dp[0]));
            check("shown_a", 32'(shown_a), 32'(e.shown[0]));
            check("an_b", 32'(an_b), 32'(e.an[1]));
            check("seg_b", 32'(seg_b), 32'(e.seg[1]));
            check("dp_b", 32'(dp_b), 32'(e.dp[1]));
            check("shown_b", 32'(shown_b), 32'(e.shown[1]));
            check("an_c", 32'(an_c), 32'(e.an[2][0]));
            check("seg_c", 32'(seg_c), 32'(e.seg[2]));
            check("dp_c", 32'(dp_c), 32'(e.dp[2]));
            check("shown_c", 32'(shown_c), 32'(e.shown[2][3:0]));
        end
    end

    task automatic wait_an_a(input logic [3:0] target, input string tag);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk); #1;
            if (an_a == target) hit = 1;
        end
        if (!hit) check({tag, "_timeout"}, 32'(an_a), 32'(target));
    endtask

    task automatic capture(input logic [15:0] data, input logic [3:0] dps);
        in_valid = 1'b1; in_data = data; dp_in = dps;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c;
        bit hit;
        rst = 1'b1; in_valid = 1'b0; freeze = 1'b0; in_data = '0; dp_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: reset mid-scan
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_an", 32'(an_a), 32'h0000000F);
        check("rst_seg", 32'(seg_a), 32'h0000007F);
        check("rst_dp", 32'(dp_a), 32'h00000001);
        check("rst_shown", 32'(shown_a), 32'h00000000);
        rst = 1'b0;
        @(negedge clk); #1;
        check("first_an", 32'(an_a), 32'h0000000E);
        check("first_seg", 32'(seg_a), 32'(7'b1000000));

        // 2: capture and scan sequence
        @(negedge clk);
        capture(16'h12A0, 4'b0100);
        #1 check("cap_shown", 32'(shown_a), 32'h000012A0);
        wait_an_a(4'b1101, "slot1");
        check("slot1_seg", 32'(seg_a), 32'(7'b0001000));
        wait_an_a(4'b1011, "slot2");
        check("slot2_seg", 32'(seg_a), 32'(7'b0100100));
        check("slot2_dp", 32'(dp_a), 32'h00000000);
        wait_an_a(4'b0111, "slot3");
        check("slot3_seg", 32'(seg_a), 32'(7'b1111001));

        // 3: leading-zero blanking versus none
        @(negedge clk);
        capture(16'h0007, 4'b1110);
        @(negedge clk);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            if (an_a != 4'hF) begin
                cnt_a++;
                check("lz_an_a", 32'(an_a), 32'h0000000E);
                check("lz_seg_a", 32'(seg_a), 32'(7'b1111000));
            end
            if (an_b != 4'hF) cnt_b++;
        end
        check("lz_lit_a", 32'(cnt_a), 32'd4);
        check("lz_lit_b", 32'(cnt_b), 32'd16);

        // 4: freeze holds the display and refuses captures
        @(negedge clk);
        capture(16'hBEEF, 4'b0000);
        freeze = 1'b1; in_valid = 1'b1; in_data = 16'h0001;
        #1 check("frz_ready", 32'(in_ready_a), 32'h00000000);
        repeat (3) @(negedge clk);
        #1 check("frz_shown", 32'(shown_a), 32'h0000BEEF);
        freeze = 1'b0;
        #1 check("unfrz_ready", 32'(in_ready_a), 32'h00000001);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("unfrz_shown", 32'(shown_a), 32'h00000001);

        // 5: capture on the same edge as the tick into idx 1
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (m_div[0] == 3 && m_idx[0] == 0) hit = 1;
        end
        if (!hit) check("coin_timeout", 32'(m_idx[0]), 32'd0);
        capture(16'h5555, 4'b0000);
        #1 check("coin_mid_an", 32'(an_a), 32'h0000000E);
        check("coin_mid_seg", 32'(seg_a), 32'(7'b1111001));
        @(negedge clk); #1;
        check("coin_an", 32'(an_a), 32'h0000000D);
        check("coin_seg", 32'(seg_a), 32'(7'b0010010));

        // 6: single-digit instance, never blanked
        @(negedge clk);
        capture(16'h000F, 4'b0000);
        @(negedge clk);
        cnt_c = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (an_c == 1'b0 && seg_c == 7'b0001110) cnt_c++;
        end
        check("one_digit_lit", 32'(cnt_c), 32'd8);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
